// File: rtl/msrv32_reg_block_2.sv
// Decode-to-execute pipeline register of the MSRV32 core: every decoded field,
// operand and PC value is captured on the rising clock edge and held for one cycle.
module msrv32_reg_block_2 (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [11:0] csr_addr_in,
  input  logic [31:0] rs1_in,
  input  logic [31:0] rs2_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_plus_4_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] imm_in,
  input  logic [3:0]  alu_opcode_in,
  input  logic [1:0]  load_size_in,
  input  logic [2:0]  wb_mux_sel_in,
  input  logic [2:0]  csr_op_in,
  input  logic        load_unsigned_in,
  input  logic        alu_src_in,
  input  logic        csr_wr_en_in,
  input  logic        rf_wr_en_in,
  input  logic        branch_taken_in,
  output logic [4:0]  rd_addr_reg_out,
  output logic [11:0] csr_addr_reg_out,
  output logic [31:0] rs1_reg_out,
  output logic [31:0] rs2_reg_out,
  output logic [31:0] pc_reg_out,
  output logic [31:0] pc_plus_4_reg_out,
  output logic [31:0] iadder_out_reg_out,
  output logic [31:0] imm_reg_out,
  output logic [3:0]  alu_opcode_reg_out,
  output logic [1:0]  load_size_reg_out,
  output logic [2:0]  wb_mux_sel_reg_out,
  output logic [2:0]  csr_op_reg_out,
  output logic        load_unsigned_reg_out,
  output logic        alu_src_reg_out,
  output logic        csr_wr_en_reg_out,
  output logic        rf_wr_en_reg_out
);

  // Flushing is decided upstream, so the taken flag never touches this stage.
  logic unused_branch_taken;
  assign unused_branch_taken = branch_taken_in;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      rd_addr_reg_out       <= '0;
      csr_addr_reg_out      <= '0;
      rs1_reg_out           <= '0;
      rs2_reg_out           <= '0;
      pc_reg_out            <= '0;
      pc_plus_4_reg_out     <= '0;
      iadder_out_reg_out    <= '0;
      imm_reg_out           <= '0;
      alu_opcode_reg_out    <= '0;
      load_size_reg_out     <= '0;
      wb_mux_sel_reg_out    <= '0;
      csr_op_reg_out        <= '0;
      load_unsigned_reg_out <= 1'b0;
      alu_src_reg_out       <= 1'b0;
      csr_wr_en_reg_out     <= 1'b0;
      rf_wr_en_reg_out      <= 1'b0;
    end else begin
      rd_addr_reg_out       <= rd_addr_in;
      csr_addr_reg_out      <= csr_addr_in;
      rs1_reg_out           <= rs1_in;
      rs2_reg_out           <= rs2_in;
      pc_reg_out            <= pc_in;
      pc_plus_4_reg_out     <= pc_plus_4_in;
      iadder_out_reg_out    <= iadder_in;
      imm_reg_out           <= imm_in;
      alu_opcode_reg_out    <= alu_opcode_in;
      load_size_reg_out     <= load_size_in;
      wb_mux_sel_reg_out    <= wb_mux_sel_in;
      csr_op_reg_out        <= csr_op_in;
      load_unsigned_reg_out <= load_unsigned_in;
      alu_src_reg_out       <= alu_src_in;
      csr_wr_en_reg_out     <= csr_wr_en_in;
      rf_wr_en_reg_out      <= rf_wr_en_in;
    end
  end

endmodule

// File: tb/tb_msrv32_reg_block_2.sv
// Randomized bench for the decode/execute pipeline register; a one-deep
// capture model predicts every output field after each edge and reset event.
module tb_msrv32_reg_block_2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [11:0] csr_addr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] iadder;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [1:0]  load_size;
    logic [2:0]  wb_sel;
    logic [2:0]  csr_op;
    logic        load_uns;
    logic        alu_src;
    logic        csr_we;
    logic        rf_we;
  } fields_t;

  localparam int W = $bits(fields_t);

  logic    clk_in = 1'b0;
  logic    reset_in;
  logic    branch_taken_in;
  fields_t stim;
  fields_t obs;
  fields_t exp_f;

  int checks = 0;
  int errors = 0;

  logic [4:0]  o_rd;
  logic [11:0] o_csr_addr;
  logic [31:0] o_rs1, o_rs2, o_pc, o_pc4, o_iadder, o_imm;
  logic [3:0]  o_alu_op;
  logic [1:0]  o_load_size;
  logic [2:0]  o_wb_sel, o_csr_op;
  logic        o_load_uns, o_alu_src, o_csr_we, o_rf_we;

  assign obs = {o_rd, o_csr_addr, o_rs1, o_rs2, o_pc, o_pc4, o_iadder, o_imm,
                o_alu_op, o_load_size, o_wb_sel, o_csr_op,
                o_load_uns, o_alu_src, o_csr_we, o_rf_we};

  always #5 clk_in = ~clk_in;

  msrv32_reg_block_2 dut (
    .clk_in                (clk_in),
    .reset_in              (reset_in),
    .rd_addr_in            (stim.rd),
    .csr_addr_in           (stim.csr_addr),
    .rs1_in                (stim.rs1),
    .rs2_in                (stim.rs2),
    .pc_in                 (stim.pc),
    .pc_plus_4_in          (stim.pc4),
    .iadder_in             (stim.iadder),
    .imm_in                (stim.imm),
    .alu_opcode_in         (stim.alu_op),
    .load_size_in          (stim.load_size),
    .wb_mux_sel_in         (stim.wb_sel),
    .csr_op_in             (stim.csr_op),
    .load_unsigned_in      (stim.load_uns),
    .alu_src_in            (stim.alu_src),
    .csr_wr_en_in          (stim.csr_we),
    .rf_wr_en_in           (stim.rf_we),
    .branch_taken_in       (branch_taken_in),
    .rd_addr_reg_out       (o_rd),
    .csr_addr_reg_out      (o_csr_addr),
    .rs1_reg_out           (o_rs1),
    .rs2_reg_out           (o_rs2),
    .pc_reg_out            (o_pc),
    .pc_plus_4_reg_out     (o_pc4),
    .iadder_out_reg_out    (o_iadder),
    .imm_reg_out           (o_imm),
    .alu_opcode_reg_out    (o_alu_op),
    .load_size_reg_out     (o_load_size),
    .wb_mux_sel_reg_out    (o_wb_sel),
    .csr_op_reg_out        (o_csr_op),
    .load_unsigned_reg_out (o_load_uns),
    .alu_src_reg_out       (o_alu_src),
    .csr_wr_en_reg_out     (o_csr_we),
    .rf_wr_en_reg_out      (o_rf_we)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rd"},        32'(obs.rd),        32'(exp_f.rd));
    check({tag, ".csr_addr"},  32'(obs.csr_addr),  32'(exp_f.csr_addr));
    check({tag, ".rs1"},       obs.rs1,            exp_f.rs1);
    check({tag, ".rs2"},       obs.rs2,            exp_f.rs2);
    check({tag, ".pc"},        obs.pc,             exp_f.pc);
    check({tag, ".pc4"},       obs.pc4,            exp_f.pc4);
    check({tag, ".iadder"},    obs.iadder,         exp_f.iadder);
    check({tag, ".imm"},       obs.imm,            exp_f.imm);
    check({tag, ".alu_op"},    32'(obs.alu_op),    32'(exp_f.alu_op));
    check({tag, ".load_size"}, 32'(obs.load_size), 32'(exp_f.load_size));
    check({tag, ".wb_sel"},    32'(obs.wb_sel),    32'(exp_f.wb_sel));
    check({tag, ".csr_op"},    32'(obs.csr_op),    32'(exp_f.csr_op));
    check({tag, ".load_uns"},  32'(obs.load_uns),  32'(exp_f.load_uns));
    check({tag, ".alu_src"},   32'(obs.alu_src),   32'(exp_f.alu_src));
    check({tag, ".csr_we"},    32'(obs.csr_we),    32'(exp_f.csr_we));
    check({tag, ".rf_we"},     32'(obs.rf_we),     32'(exp_f.rf_we));
  endtask

  // One rising edge: the model captures the stimulus only if out of reset.
  task automatic tick(input string tag);
    @(posedge clk_in);
    if (reset_in) exp_f = stim;
    else          exp_f = '0;
    #1;
    check_all(tag);
    $display("txn %s: rst=%0b bt=%0b pc=%h rd=%0d rf_we=%0b", tag, reset_in,
             branch_taken_in, obs.pc, obs.rd, obs.rf_we);
  endtask

  task automatic randomize_stim();
    logic [255:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    stim = fields_t'(r[W-1:0]);
    branch_taken_in = 1'($urandom_range(0, 1));
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear at once.
  task automatic reset_pulse(input string tag);
    reset_in = 1'b0;
    exp_f = '0;
    #1;
    check_all(tag);
    #1;
    reset_in = 1'b1;
  endtask

  initial begin
    fields_t saved;
    logic [W-1:0] v;

    reset_in = 1'b0;
    branch_taken_in = 1'b1;
    stim = '1;
    exp_f = '0;
    #1;
    check_all("rst_init");
    for (int i = 0; i < 3; i++) tick("rst_hold");

    @(negedge clk_in);
    reset_in = 1'b1;
    #1;
    check_all("pre_edge");
    tick("all_ones");

    // Streaming: each cycle's values appear exactly one edge later.
    stim = '0;
    stim.pc = 32'h100; stim.pc4 = 32'h104; stim.rd = 5'd5; stim.rf_we = 1'b1;
    tick("stream1");
    stim.pc = 32'h104; stim.pc4 = 32'h108; stim.rd = 5'd6; stim.rf_we = 1'b0;
    tick("stream2");

    stim = fields_t'({8{32'hA5A5A5A5}});
    tick("a5_load");
    #2;
    reset_pulse("a5_async_rst");
    tick("after_rst");

    // branch_taken_in must not influence the captured fields.
    randomize_stim();
    stim.rf_we = 1'b1;
    saved = stim;
    branch_taken_in = 1'b1;
    tick("bt1");
    stim = '0;
    tick("bt_gap");
    stim = saved;
    branch_taken_in = 1'b0;
    tick("bt0");

    // Walking one across every bit of every field.
    branch_taken_in = 1'b0;
    for (int i = 0; i < W; i++) begin
      v = '0;
      v[i] = 1'b1;
      stim = fields_t'(v);
      tick("walk1");
    end

    for (int n = 0; n < 300; n++) begin
      randomize_stim();
      if ($urandom_range(0, 19) == 0) begin
        #2;
        reset_pulse("rnd_async_rst");
      end else if ($urandom_range(0, 29) == 0) begin
        reset_in = 1'b0;
        tick("rnd_rst_edge");
        reset_in = 1'b1;
        continue;
      end
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
